mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port eBPF memory (combinational read, write on rising clock edge) between the instruction-fetch requester (port A, read-only) and the load/store requester (port B, read/write). It sits between the CPU core and the memory instance. It grants at most one access per cycle, registers read data, and returns a one-cycle acknowledge to the winning requester.

## Interface
- data_size, 64, word width in bits
- address_size, 12, word address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- a_req  in  1  fetch request; held high until a_ack
- a_address  in  address_size  fetch word address
- a_ack  out  1  one-cycle pulse; a_rdata valid this cycle
- a_rdata  out  data_size  registered fetch data
- b_req  in  1  data request; held high until b_ack
- b_we  in  1  1 = write, 0 = read; stable while b_req high
- b_address  in  address_size  data word address
- b_wdata  in  data_size  write data
- b_ack  out  1  one-cycle pulse; read data / write completion
- b_rdata  out  data_size  registered load data
- mem_address  out  address_size  to memory address
- mem_data_in  out  data_size  to memory data_in
- mem_write_enable  out  1  to memory write_enable
- mem_data_out  in  data_size  from memory data_out

## Operation
- Eligibility: port X is eligible in a cycle when x_req=1 and x_ack=0; a port is never granted in its own ack cycle, which prevents double service of a held request.
- Grant is combinational from eligibility and the last-grant register. Exactly one port or none is granted.
- Granted A: mem_address=a_address, mem_write_enable=0.
- Granted B: mem_address=b_address, mem_data_in=b_wdata, mem_write_enable=b_we.
- No grant: mem_address=0, mem_data_in=0, mem_write_enable=0.
- At the clock edge ending a grant cycle:
  - Granted port's ack register is set to 1. The other port's ack is cleared.
  - For a read, mem_data_out is captured into that port's rdata.
  - For a B write, b_rdata holds its previous value, and the memory commits on the same edge.
- last_grant register: updated to the granted port on every grant; unchanged when idle.
- Both eligible: resolved per Configuration.
- Requesters may change address and data, or drop req, in the ack cycle. A new request presented in the ack cycle is eligible the following cycle.
- a_rdata and b_rdata hold their values until the next read on that port.

## Timing
- Latency: request sampled in cycle N (granted), ack and data in cycle N+1.
- Single port continuous request: one access per 2 cycles.
- Both ports continuously requesting: one access per cycle total, alternating A/B in the ack-blocking pattern.
- Write to address X then read of X on the other port in the next cycle returns the new data.
- Reset values: a_ack=0, b_ack=0, a_rdata=0, b_rdata=0, last_grant=B.
- mem_write_enable is gated combinationally by reset, so it is 0 immediately on reset assertion.
- Reset mid-access: a pending ack is discarded, and no ack is issued after reset deasserts. A write whose edge preceded reset assertion is committed.
- First cycle after reset deassertion: normal arbitration.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on a tie, grant the port not equal to last_grant. The first tie after reset goes to A.
- Undefined: fixed priority, B always wins a tie. last_grant is still maintained but does not affect the decision.
- Ack-blocking still guarantees A is served at least every other cycle under constant B demand.

## Test plan
- Reset, then a_req=1, a_address=3, memory[3]=64'hB4070000_0000000B -> a_ack=1 one cycle later with a_rdata=64'hB4070000_0000000B; a_ack=0 the next cycle if req was dropped.
- b_req=1, b_we=1, b_address=10, b_wdata=64'h1234 -> mem_write_enable=1 for exactly one cycle, b_ack next cycle, b_rdata unchanged. A following b read of address 10 returns 64'h1234.
- a_req and b_req both held high for 8 cycles with round-robin defined -> grants A,B,A,B,… and 4 acks per port. With the macro undefined -> B first, then alternating.
- Same-cycle write by B to address 5 (64'hFF) and fetch by A of address 5 in the next cycle -> a_rdata=64'hFF.
- Reset asserted in the ack-pending cycle of a b read -> b_ack stays 0 and b_rdata=0. mem_write_enable=0 immediately during reset.
- a_req held continuously with address changing each ack -> accesses on cycles 0,2,4; a_ack on 1,3,5; no duplicate service of the same address.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory (combinational read, write on
// the rising edge) between an instruction-fetch port (A, read-only) and a
// load/store port (B, read/write). At most one access is granted per cycle;
// the winner receives a one-cycle ack together with registered read data.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN defined   -> a tie goes to the port that did not win last.
//   MEM_ARB_ROUND_ROBIN_EN undefined -> a tie always goes to B (fixed priority).
// In both builds a port is blocked in its own ack cycle. This prevents a held
// request from being served twice, and it means A cannot be starved by B.
module mem_arbiter #(
  parameter int data_size    = 64,
  parameter int address_size = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  // fetch port (read-only)
  input  logic                    a_req,
  input  logic [address_size-1:0] a_address,
  output logic                    a_ack,
  output logic [data_size-1:0]    a_rdata,
  // load/store port
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [address_size-1:0] b_address,
  input  logic [data_size-1:0]    b_wdata,
  output logic                    b_ack,
  output logic [data_size-1:0]    b_rdata,
  // memory side
  output logic [address_size-1:0] mem_address,
  output logic [data_size-1:0]    mem_data_in,
  output logic                    mem_write_enable,
  input  logic [data_size-1:0]    mem_data_out
);

  // Registered state. last_grant_b_q = 1 means B won the most recent grant.
  logic                 a_ack_q, a_ack_d;
  logic                 b_ack_q, b_ack_d;
  logic [data_size-1:0] a_rdata_q, a_rdata_d;
  logic [data_size-1:0] b_rdata_q, b_rdata_d;
  logic                 last_grant_b_q, last_grant_b_d;

  logic a_elig, b_elig;
  logic grant_a, grant_b;

  // Eligibility and grant decision. A port in its ack cycle is not eligible.
  // Nothing is granted while reset is high.
  always_comb begin
    a_elig  = a_req & ~a_ack_q & ~reset;
    b_elig  = b_req & ~b_ack_q & ~reset;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_elig && b_elig) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // Tie: the port that did not win last time gets the grant.
      if (last_grant_b_q) begin
        grant_a = 1'b1;
      end else begin
        grant_b = 1'b1;
      end
`else
      // Tie: B always wins.
      grant_b = 1'b1;
`endif
    end else begin
      grant_a = a_elig;
      grant_b = b_elig;
    end
  end

  // Memory-side drive. When idle, all memory-side outputs are 0.
  // The write enable is also masked by reset, so it drops to 0 as soon as
  // reset is asserted, without waiting for a clock edge.
  always_comb begin
    mem_address      = '0;
    mem_data_in      = '0;
    mem_write_enable = 1'b0;
    if (grant_a) begin
      mem_address = a_address;
    end else if (grant_b) begin
      mem_address      = b_address;
      mem_data_in      = b_wdata;
      mem_write_enable = b_we & ~reset;
    end
  end

  // Next state. The ack follows the grant. Read data is captured only for a
  // read on that port. last_grant holds its value while idle.
  always_comb begin
    a_ack_d        = grant_a;
    b_ack_d        = grant_b;
    a_rdata_d      = a_rdata_q;
    b_rdata_d      = b_rdata_q;
    last_grant_b_d = last_grant_b_q;
    if (grant_a) begin
      a_rdata_d      = mem_data_out;
      last_grant_b_d = 1'b0;
    end
    if (grant_b) begin
      last_grant_b_d = 1'b1;
      if (!b_we) begin
        b_rdata_d = mem_data_out;
      end
    end
  end

  // State registers. Reset clears any pending ack and both read-data
  // registers, and it sets last_grant to B so that the first tie goes to A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_ack_q        <= 1'b0;
      b_ack_q        <= 1'b0;
      a_rdata_q      <= '0;
      b_rdata_q      <= '0;
      last_grant_b_q <= 1'b1;
    end else begin
      a_ack_q        <= a_ack_d;
      b_ack_q        <= b_ack_d;
      a_rdata_q      <= a_rdata_d;
      b_rdata_q      <= b_rdata_d;
      last_grant_b_q <= last_grant_b_d;
    end
  end

  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

  // The two grants are never active in the same cycle.
  grant_onehot_a : assert property (@(posedge clk) disable iff (reset) !(grant_a && grant_b));

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. The bench contains a behavioural memory that is
// attached to the DUT. It also keeps a separate transaction-level reference
// model: a reference memory image, the expected acks and read data, and
// which port was served last. Directed scenarios run first, followed by a
// long randomized phase in which two independent requesters operate.
module tb_mem_arbiter;
  localparam int DW = 64;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_ack, b_req, b_we, b_ack;
  logic [AW-1:0] a_address, b_address, mem_address;
  logic [DW-1:0] a_rdata, b_wdata, b_rdata, mem_data_in, mem_data_out;
  logic          mem_write_enable;

  always #5 clk = ~clk;

  mem_arbiter #(.data_size(DW), .address_size(AW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_address(a_address), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_address(b_address), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out)
  );

  // Environment memory: combinational read, write on the rising edge. It is
  // preloaded through the load port while the DUT is held in reset.
  logic [DW-1:0] env_mem [0:4095];
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  assign mem_data_out = env_mem[mem_address];
  always @(posedge clk) begin
    if (load_en) env_mem[load_addr] <= load_data;
    else if (mem_write_enable) env_mem[mem_address] <= mem_data_in;
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:4095];
  logic          m_a_ack, m_b_ack, m_last_b;
  logic [DW-1:0] m_a_rdata, m_b_rdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_a_ack = 1'b0; m_b_ack = 1'b0; m_last_b = 1'b1;
    m_a_rdata = '0; m_b_rdata = '0;
  endtask

  // One clock cycle. It is entered just after a rising edge, once the inputs
  // have been driven. The task predicts who is served and checks the
  // memory-side drive. After the next edge it updates the model and checks
  // the registered outputs.
  task automatic step();
    logic          ea, eb, ga, gb;
    logic [AW-1:0] aa, ba;
    logic          bwe;
    logic [DW-1:0] bwd;
    #1;
    ea = a_req && !m_a_ack;
    eb = b_req && !m_b_ack;
    if (ea && eb) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ga = m_last_b;
`else
      ga = 1'b0;
`endif
      gb = !ga;
    end else begin
      ga = ea;
      gb = eb;
    end
    aa = a_address; ba = b_address; bwe = b_we; bwd = b_wdata;
    check_val("mem_we", 64'(mem_write_enable), 64'(gb && bwe));
    check_val("mem_addr", 64'(mem_address), ga ? 64'(aa) : (gb ? 64'(ba) : 64'd0));
    if (!ga) check_val("mem_din", mem_data_in, gb ? bwd : 64'd0);
    @(posedge clk);
    #1;
    m_a_ack = ga;
    m_b_ack = gb;
    if (ga) begin
      m_a_rdata = ref_mem[aa];
      $display("A read  addr=%0d data=%h", aa, m_a_rdata);
    end
    if (gb) begin
      if (bwe) begin
        ref_mem[ba] = bwd;
        $display("B write addr=%0d data=%h", ba, bwd);
      end else begin
        m_b_rdata = ref_mem[ba];
        $display("B read  addr=%0d data=%h", ba, m_b_rdata);
      end
    end
    if (ga || gb) m_last_b = gb;
    check_val("a_ack", 64'(a_ack), 64'(m_a_ack));
    check_val("b_ack", 64'(b_ack), 64'(m_b_ack));
    check_val("a_rdata", a_rdata, m_a_rdata);
    check_val("b_rdata", b_rdata, m_b_rdata);
  endtask

  initial begin
    int            acks_a, acks_b;
    logic          a_pend, b_pend;
    logic          exp_first_a;
    logic [DW-1:0] v;

    reset = 1'b1;
    a_req = 0; a_address = '0; b_req = 0; b_we = 0; b_address = '0; b_wdata = '0;
    load_en = 0; load_addr = '0; load_data = '0;
    model_reset();

    // Preload addresses 0..15 while the DUT is held in reset.
    for (int i = 0; i < 16; i++) begin
      v = (i == 3) ? 64'hB4070000_0000000B : {$urandom, $urandom};
      load_en = 1; load_addr = AW'(i); load_data = v; ref_mem[i] = v;
      @(posedge clk); #1;
    end
    load_en = 0;
    check_val("rst_a_ack", 64'(a_ack), 64'd0);
    check_val("rst_b_ack", 64'(b_ack), 64'd0);
    check_val("rst_a_rdata", a_rdata, 64'd0);
    check_val("rst_b_rdata", b_rdata, 64'd0);
    check_val("rst_mem_we", 64'(mem_write_enable), 64'd0);
    reset = 1'b0;

    // Fetch from address 3, then drop the request in the ack cycle.
    a_req = 1; a_address = 12'd3; step();
    check_val("fetch3_data", a_rdata, 64'hB4070000_0000000B);
    check_val("fetch3_ack", 64'(a_ack), 64'd1);
    a_req = 0; step();
    check_val("fetch3_ack_drop", 64'(a_ack), 64'd0);

    // B writes address 10, then reads it back.
    b_req = 1; b_we = 1; b_address = 12'd10; b_wdata = 64'h1234; step();
    b_req = 0; b_we = 0; step();
    b_req = 1; b_we = 0; step();
    check_val("rd10", b_rdata, 64'h1234);
    b_req = 0; step();

    // Both ports held for 8 cycles: the grants alternate with 4 acks each.
    // The last grant was B, so the first tie goes to A under round robin.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_first_a = 1'b1;
`else
    exp_first_a = 1'b0;
`endif
    acks_a = 0; acks_b = 0;
    a_req = 1; a_address = 12'd1; b_req = 1; b_we = 0; b_address = 12'd2;
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 0) check_val("tie_first_a", 64'(a_ack), 64'(exp_first_a));
      acks_a += int'(a_ack); acks_b += int'(b_ack);
    end
    check_val("tie_acks_a", 64'(acks_a), 64'd4);
    check_val("tie_acks_b", 64'(acks_b), 64'd4);
    a_req = 0; b_req = 0; step();

    // B writes address 5, then A fetches address 5 in the next cycle.
    b_req = 1; b_we = 1; b_address = 12'd5; b_wdata = 64'hFF; step();
    b_req = 0; b_we = 0; a_req = 1; a_address = 12'd5; step();
    check_val("raw5", a_rdata, 64'hFF);
    a_req = 0; step();

    // A holds its request and changes the address on each ack: one fetch
    // every two cycles.
    acks_a = 0;
    a_req = 1; a_address = 12'd0;
    for (int c = 0; c < 6; c++) begin
      step();
      check_val("stream_ack", 64'(a_ack), 64'((c % 2) == 0));
      if (a_ack) begin
        acks_a++;
        a_address = a_address + 1'b1;
      end
    end
    check_val("stream_cnt", 64'(acks_a), 64'd3);
    a_req = 0; step();

    // Reset asserted during a B grant cycle. The write enable drops at once,
    // the read data clears, no ack appears, and the write is not committed.
    b_req = 1; b_we = 1; b_address = 12'd7; b_wdata = {$urandom, $urandom};
    #1;
    check_val("we_pre_rst", 64'(mem_write_enable), 64'd1);
    reset = 1'b1;
    #1;
    check_val("we_in_rst", 64'(mem_write_enable), 64'd0);
    check_val("b_rdata_rst", b_rdata, 64'd0);
    check_val("a_rdata_rst", a_rdata, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    b_req = 0; b_we = 0;
    step(); step();
    b_req = 1; b_we = 0; b_address = 12'd7; step();
    b_req = 0; step();

    // Randomized phase: two independent requesters.
    a_pend = 0; b_pend = 0;
    for (int c = 0; c < 1500; c++) begin
      if (m_a_ack) a_pend = 0;
      if (m_b_ack) b_pend = 0;
      if (!a_pend) begin
        a_address = AW'($urandom_range(0, 15));
        if ($urandom_range(0, 99) < 60) a_pend = 1;
      end
      if (!b_pend) begin
        b_address = AW'($urandom_range(0, 15));
        b_we      = $urandom_range(0, 1) == 1;
        b_wdata   = {$urandom, $urandom};
        if ($urandom_range(0, 99) < 60) b_pend = 1;
      end
      a_req = a_pend;
      b_req = b_pend;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
